risac_mem_arbiter: RTL and testbench
====================================

# risac_mem_arbiter

Two-port round-robin arbiter that shares the single-port on-chip memory (1024 x 32, byte-enabled, one-cycle read latency) between the risac core's instruction-fetch master and data master. It sits between the two core masters and the memory slave in the SoC, issues at most one memory access per cycle, and routes read data back to the master that issued the read.

## Interface
Parameters:
- ADDR_W, 10, word-address width (memory depth 2^ADDR_W)
- DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- i_address  in  ADDR_W  fetch word address
- i_read  in  1  fetch read request
- i_waitrequest  out  1  high: fetch request not accepted this cycle
- i_readdata  out  DATA_W  fetch read data
- i_readdatavalid  out  1  i_readdata valid this cycle
- d_address  in  ADDR_W  data word address
- d_read / d_write  in  1  data read / write request (both high is illegal)
- d_byteenable  in  DATA_W/8  write lane enables
- d_writedata  in  DATA_W  write data
- d_waitrequest  out  1  high: data request not accepted this cycle
- d_readdata  out  DATA_W  data read data
- d_readdatavalid  out  1  d_readdata valid this cycle
- m_address  out  ADDR_W  to memory
- m_chipselect, m_write, m_clken  out  1  to memory
- m_byteenable  out  DATA_W/8  to memory
- m_writedata  out  DATA_W  to memory
- m_readdata  in  DATA_W  from memory, valid one cycle after the accepted read

## Operation
- A request is "accepted" in a cycle when its read/write is high and its waitrequest is low; masters hold all request signals stable until accepted.
- Grant is combinational from current requests plus the last_grant register: one requester wins outright; on a tie, the requester not in last_grant wins.
- last_grant updates to the winner on every cycle a request is accepted; it is unchanged in idle cycles.
- Loser's waitrequest = 1; winner's waitrequest = 0; with no request both waitrequests = 0.
- Memory drive: m_chipselect = accept; m_write = accept & winner is data & d_write; m_address and m_writedata come from the winner; m_byteenable = d_byteenable for data writes, all ones for any read; m_clken = 1 always.
- Read tracking: register rd_pend (1 b) and rd_owner (1 b); set on an accepted read, cleared otherwise. Writes never set rd_pend.
- Return path: i_readdatavalid = rd_pend & owner is fetch, d_readdatavalid = rd_pend & owner is data. Both readdata outputs are driven from m_readdata unconditionally; only valid flags are steered.
- d_read & d_write both high: treated as a write; no readdatavalid returned.

## Timing
- Reset values (reset_n low, asynchronous): last_grant = data (fetch wins the first tie); rd_pend = 0; both readdatavalid = 0; the combinational outputs follow the inputs.
- Read latency: accepted in cycle N -> readdatavalid in cycle N+1 exactly; no stall path.
- Back-to-back: one master alone is accepted every cycle; full throughput of 1 access per cycle. Both requesting continuously -> strict alternation F, D, F, D...
- Write accepted in cycle N is committed at the end of cycle N; a read of the same address accepted in N+1 returns the new data in N+2.
- Reset asserted mid-read: pending read is dropped, no readdatavalid after reset release.
- No combinational path from m_readdata to any waitrequest.

## Structure
- Shared package risac_mem_pkg: ADDR_W/DATA_W defaults, requester index constants (REQ_FETCH = 0, REQ_DATA = 1).
- Sub-module risac_rr_arb2: 2-way round-robin (request[1:0] -> grant[1:0], last_grant register, advance input); the top level holds the mux, read tracking and steering.

## Test plan
- Reset, then fetch and data both read (i 0x010, d 0x020) in the same cycle -> fetch accepted in cycle 0, data accepted in cycle 1; i_readdatavalid in cycle 1, d_readdatavalid in cycle 2, carrying the preloaded words.
- Both masters request continuously for 8 cycles -> grants alternate F,D,F,D,F,D,F,D; each master gets 4 accepts; no lost or duplicated readdatavalid.
- Data write 0xDEADBEEF to 0x3FF with byteenable 0b0101, then fetch read 0x3FF -> returns 0xxxADxxEF with the original bytes 3 and 1 preserved; readdatavalid only for the read.
- Fetch alone reads 0x000..0x007 on consecutive cycles -> 8 accepts, waitrequest never high, 8 consecutive i_readdatavalid one cycle after each accept.
- Assert reset_n low in the cycle after a data read is accepted -> d_readdatavalid = 0 immediately and stays 0 after release; the next tie goes to fetch.
- d_read and d_write both high to 0x005 -> memory write occurs, no d_readdatavalid.

Source files
------------

// File: rtl/risac_mem_pkg.sv
// Shared widths, requester indices and owner encoding for the risac memory arbiter.
package risac_mem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int REQ_FETCH  = 0;
  localparam int REQ_DATA   = 1;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;
endpackage

// File: rtl/risac_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last winner registered on advance.
module risac_rr_arb2
  import risac_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  owner_e last_q;
  owner_e last_d;

  // A tie goes to whichever requester did not win last time.
  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = (last_q == OWN_DATA) ? 2'b01 : 2'b10;
    end
  end

  assign last_d = gnt_o[REQ_DATA] ? OWN_DATA : OWN_FETCH;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= OWN_DATA;
    end else if (advance_i) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/risac_mem_arbiter.sv
// Shares one single-port memory between the fetch and data masters, one access per cycle;
// read data returns exactly one cycle after acceptance and is steered by valid flags only.
module risac_mem_arbiter
  import risac_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic                i_waitrequest,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_readdatavalid,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_byteenable,
  input  logic [DATA_W-1:0]   d_writedata,
  output logic                d_waitrequest,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_readdatavalid,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic                m_clken,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       accept;
  logic       data_wr;

  logic       rd_pend_q, rd_pend_d;
  owner_e     rd_owner_q, rd_owner_d;

  assign req[REQ_FETCH] = i_read;
  assign req[REQ_DATA]  = d_read | d_write;
  assign accept         = |req;

  risac_rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req),
    .advance_i (accept),
    .gnt_o     (gnt)
  );

  assign i_waitrequest = req[REQ_FETCH] & ~gnt[REQ_FETCH];
  assign d_waitrequest = req[REQ_DATA]  & ~gnt[REQ_DATA];

  // Read+write together from the data master is treated as a plain write.
  assign data_wr = gnt[REQ_DATA] & d_write;

  assign m_chipselect = accept;
  assign m_write      = data_wr;
  assign m_clken      = 1'b1;
  assign m_address    = gnt[REQ_DATA] ? d_address : i_address;
  assign m_writedata  = d_writedata;
  assign m_byteenable = data_wr ? d_byteenable : {(DATA_W/8){1'b1}};

  assign rd_pend_d  = accept & ~data_wr;
  assign rd_owner_d = gnt[REQ_DATA] ? OWN_DATA : OWN_FETCH;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_FETCH;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign i_readdata      = m_readdata;
  assign d_readdata      = m_readdata;
  assign i_readdatavalid = rd_pend_q & (rd_owner_q == OWN_FETCH);
  assign d_readdatavalid = rd_pend_q & (rd_owner_q == OWN_DATA);

endmodule

// File: tb/tb_risac_mem_arbiter.sv
// Randomised and directed bench for risac_mem_arbiter with a memory slave model,
// a request-level reference model and a scoreboard for the read-return path.
module tb_risac_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        i_readdatavalid;
  logic [9:0]  d_address;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        d_readdatavalid;
  logic [9:0]  m_address;
  logic        m_chipselect;
  logic        m_write;
  logic        m_clken;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  always #5 clk = ~clk;

  risac_mem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_address       (i_address),
    .i_read          (i_read),
    .i_waitrequest   (i_waitrequest),
    .i_readdata      (i_readdata),
    .i_readdatavalid (i_readdatavalid),
    .d_address       (d_address),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_byteenable    (d_byteenable),
    .d_writedata     (d_writedata),
    .d_waitrequest   (d_waitrequest),
    .d_readdata      (d_readdata),
    .d_readdatavalid (d_readdatavalid),
    .m_address       (m_address),
    .m_chipselect    (m_chipselect),
    .m_write         (m_write),
    .m_clken         (m_clken),
    .m_byteenable    (m_byteenable),
    .m_writedata     (m_writedata),
    .m_readdata      (m_readdata)
  );

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } exp_t;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  exp_t        exp_i[$];
  exp_t        exp_d[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          last_g = 1;     // 0 = fetch won last, 1 = data won last
  logic        i_acc, d_acc;
  int          n_iacc = 0;
  int          n_dacc = 0;

  function automatic logic [31:0] preload(input int a);
    return 32'hC0DE_0000 | a;
  endfunction

  // Memory slave: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (m_chipselect && m_clken) begin
      if (m_write) begin
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) mem[m_address][8*b +: 8] = m_writedata[8*b +: 8];
      end else begin
        m_readdata <= mem[m_address];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor for the return path.
  always @(negedge clk) begin
    exp_t e;
    if (i_readdatavalid) begin
      if (exp_i.size() == 0) check("i_rdv_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_i.pop_front();
        check("i_rdv_cycle", cyc, e.cyc);
        check("i_readdata", i_readdata, e.dat);
      end
    end else if (exp_i.size() > 0 && exp_i[0].cyc <= cyc) begin
      e = exp_i.pop_front();
      check("i_rdv_missing", 32'd0, 32'd1);
    end
    if (d_readdatavalid) begin
      if (exp_d.size() == 0) check("d_rdv_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_d.pop_front();
        check("d_rdv_cycle", cyc, e.cyc);
        check("d_readdata", d_readdata, e.dat);
      end
    end else if (exp_d.size() > 0 && exp_d[0].cyc <= cyc) begin
      e = exp_d.pop_front();
      check("d_rdv_missing", 32'd0, 32'd1);
    end
  end

  // One bus cycle: reference arbitration + memory effects, compared against the DUT.
  task automatic tick();
    int   win;
    logic ireq, dreq;
    @(negedge clk);
    ireq = i_read;
    dreq = d_read | d_write;
    win  = -1;
    if (ireq && dreq) win = (last_g == 1) ? 0 : 1;
    else if (ireq)    win = 0;
    else if (dreq)    win = 1;
    check("i_waitrequest", i_waitrequest, ireq && win != 0);
    check("d_waitrequest", d_waitrequest, dreq && win != 1);
    check("m_chipselect", m_chipselect, win >= 0);
    check("m_write", m_write, win == 1 && d_write);
    if (win >= 0) begin
      check("m_address", m_address, (win == 1) ? d_address : i_address);
      check("m_byteenable", m_byteenable, (win == 1 && d_write) ? d_byteenable : 4'hF);
    end
    i_acc = i_read && !i_waitrequest;
    d_acc = (d_read || d_write) && !d_waitrequest;
    n_iacc += int'(i_acc);
    n_dacc += int'(d_acc);
    if (win == 0) begin
      exp_i.push_back('{cyc + 1, ref_mem[i_address]});
      last_g = 0;
    end else if (win == 1) begin
      last_g = 1;
      if (d_write) begin
        check("m_writedata", m_writedata, d_writedata);
        for (int b = 0; b < 4; b++)
          if (d_byteenable[b]) ref_mem[d_address][8*b +: 8] = d_writedata[8*b +: 8];
      end else begin
        exp_d.push_back('{cyc + 1, ref_mem[d_address]});
      end
    end
    @(posedge clk); #1;
    if (i_acc) i_read = 1'b0;
    if (d_acc) begin d_read = 1'b0; d_write = 1'b0; end
  endtask

  task automatic set_i(input logic [9:0] a);
    i_read = 1'b1; i_address = a;
  endtask

  task automatic set_d(input logic rd, input logic wr, input logic [3:0] be,
                       input logic [9:0] a, input logic [31:0] wd);
    d_read = rd; d_write = wr; d_byteenable = be; d_address = a; d_writedata = wd;
  endtask

  task automatic drain();
    int n = 0;
    while ((i_read || d_read || d_write) && n < 8) begin
      tick();
      n++;
    end
    check("drain_done", {31'd0, i_read || d_read || d_write}, 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int bi, bd;
    for (int a = 0; a < 1024; a++) begin
      mem[a]     = preload(a);
      ref_mem[a] = preload(a);
    end
    reset_n = 1'b0;
    i_read = 1'b0; i_address = '0;
    set_d(1'b0, 1'b0, 4'h0, 10'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_rdv", i_readdatavalid, 1'b0);
    check("rst_d_rdv", d_readdatavalid, 1'b0);
    check("rst_i_wait", i_waitrequest, 1'b0);
    check("rst_d_wait", d_waitrequest, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    last_g  = 1;

    // Simultaneous reads: fetch first, then data.
    set_i(10'h010);
    set_d(1'b1, 1'b0, 4'h0, 10'h020, 32'd0);
    drain();

    // Both masters continuously busy for 8 cycles.
    bi = n_iacc; bd = n_dacc;
    for (int k = 0; k < 8; k++) begin
      if (!i_read) set_i(10'($urandom_range(0, 1023)));
      if (!d_read && !d_write) set_d(1'b1, 1'b0, 4'h0, 10'($urandom_range(0, 1023)), 32'd0);
      tick();
    end
    check("cont_fetch_accepts", n_iacc - bi, 32'd4);
    check("cont_data_accepts", n_dacc - bd, 32'd4);
    drain();

    // Partial write then fetch read of the same word.
    set_d(1'b0, 1'b1, 4'b0101, 10'h3FF, 32'hDEADBEEF);
    drain();
    set_i(10'h3FF);
    tick();
    @(negedge clk);
    check("be_merge_valid", i_readdatavalid, 1'b1);
    check("be_merge_data", i_readdata, 32'hC0AD03EF);
    @(posedge clk); #1;
    tick();

    // Fetch streaming alone.
    bi = n_iacc;
    for (int a = 0; a < 8; a++) begin
      set_i(10'(a));
      tick();
    end
    check("stream_accepts", n_iacc - bi, 32'd8);
    tick(); tick();

    // Reset while a data read is outstanding.
    set_d(1'b1, 1'b0, 4'h0, 10'h040, 32'd0);
    tick();
    reset_n = 1'b0;
    #1;
    check("rst_mid_d_rdv", d_readdatavalid, 1'b0);
    exp_i.delete();
    exp_d.delete();
    last_g = 1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(); tick();
    set_i(10'h011);
    set_d(1'b1, 1'b0, 4'h0, 10'h022, 32'd0);
    drain();

    // Read and write together behave as a write.
    set_d(1'b1, 1'b1, 4'hF, 10'h005, $urandom);
    drain();
    set_i(10'h005);
    drain();

    // Random traffic over a small address window to exercise read-after-write.
    for (int k = 0; k < 300; k++) begin
      if (!i_read && $urandom_range(0, 1) == 1) set_i(10'($urandom_range(0, 31)));
      if (!d_read && !d_write && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 5))
          0, 1, 2: set_d(1'b1, 1'b0, 4'h0, 10'($urandom_range(0, 31)), 32'd0);
          3, 4:    set_d(1'b0, 1'b1, 4'($urandom_range(0, 15)), 10'($urandom_range(0, 31)), $urandom);
          default: set_d(1'b1, 1'b1, 4'($urandom_range(0, 15)), 10'($urandom_range(0, 31)), $urandom);
        endcase
      end
      tick();
    end
    drain();

    check("exp_i_empty", exp_i.size(), 32'd0);
    check("exp_d_empty", exp_d.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
